// File: rtl/snake_game_ctrl_if.sv
// Handshake bundle between the snake game sequencer and the game datapath.
// The master side is the surrounding game logic, the slave side is the sequencer.
interface snake_game_ctrl_if;
  logic       start;
  logic       hit_score;
  logic       collision;
  logic       winGame;
  logic       food_ready;
  logic       move_tick;
  logic       game_reset;
  logic       playing;
  logic       game_won;
  logic       game_over;
  logic       food_tmo;
  logic [2:0] level;

  modport master (
    output start, hit_score, collision, winGame, food_ready,
    input  move_tick, game_reset, playing, game_won, game_over, food_tmo, level
  );

  modport slave (
    input  start, hit_score, collision, winGame, food_ready,
    output move_tick, game_reset, playing, game_won, game_over, food_tmo, level
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game state machine, move_tick generation, speed-up
// with score, freeze while food is being placed, and datapath reset.
module snake_game_ctrl #(
  parameter int CNT_W       = 26,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int MIN_PERIOD  = 6_250_000,
  parameter int PERIOD_DEC  = 2_500_000,
  parameter int SPEED_STEP  = 4,
  parameter int FOOD_TMO    = 255
) (
  input logic              Clock,
  input logic              reset,
  snake_game_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WON  = 3'd3;
  localparam logic [2:0] S_LOST = 3'd4;

  localparam int WAIT_W = (FOOD_TMO < 2) ? 1 : $clog2(FOOD_TMO + 1);
  localparam int SC_W   = (SPEED_STEP < 2) ? 1 : $clog2(SPEED_STEP + 1);

  localparam logic [CNT_W-1:0]  BASE_P    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  DEC_P     = CNT_W'(PERIOD_DEC);
  localparam logic [CNT_W-1:0]  FLOOR_P   = CNT_W'(MIN_PERIOD + PERIOD_DEC);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
  localparam logic [WAIT_W-1:0] TMO_C     = WAIT_W'(FOOD_TMO);
  localparam logic [SC_W-1:0]   STEP_LAST = SC_W'(SPEED_STEP - 1);

  logic [2:0]        state_q, state_d;
  logic              start_q;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [2:0]        level_q, level_d;
  logic [SC_W-1:0]   score_cnt_q, score_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              food_tmo_q, food_tmo_d;
  logic              move_tick_q, move_tick_d;
  logic              game_reset_q, game_reset_d;
  logic              playing_q, playing_d;
  logic              game_won_q, game_won_d;
  logic              game_over_q, game_over_d;
  logic              start_edge;

  assign start_edge = bus.start & ~start_q;

  // Next-state and counter logic; a score in PLAY outranks a tick terminal count.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    period_d    = period_q;
    level_d     = level_q;
    score_cnt_d = score_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    food_tmo_d  = food_tmo_q;
    move_tick_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_PLAY;
          tick_cnt_d  = '0;
          level_d     = 3'd0;
          score_cnt_d = '0;
          food_tmo_d  = 1'b0;
          period_d    = BASE_P;
        end
      end
      S_PLAY: begin
        if (bus.winGame) begin
          state_d = S_WON;
        end else if (bus.collision) begin
          state_d = S_LOST;
        end else if (bus.hit_score) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          if (score_cnt_q == STEP_LAST) begin
            score_cnt_d = '0;
            if (level_q != 3'd7) level_d = level_q + 3'd1;
            period_d   = (period_q >= FLOOR_P) ? (period_q - DEC_P) : MIN_P;
            tick_cnt_d = '0;
          end else begin
            score_cnt_d = score_cnt_q + SC_W'(1);
          end
        end else if (tick_cnt_q == (period_q - ONE_C)) begin
          tick_cnt_d  = '0;
          move_tick_d = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + ONE_C;
        end
      end
      S_WAIT: begin
        if (bus.winGame) begin
          state_d = S_WON;
        end else if (bus.collision) begin
          state_d = S_LOST;
        end else if (bus.food_ready) begin
          state_d = S_PLAY;
        end else if (wait_cnt_q == TMO_C) begin
          state_d    = S_PLAY;
          food_tmo_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_WON, S_LOST: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered versions of the upcoming state.
  always_comb begin
    game_reset_d = (state_d == S_IDLE);
    playing_d    = (state_d == S_PLAY) || (state_d == S_WAIT);
    game_won_d   = (state_d == S_WON);
    game_over_d  = (state_d == S_LOST);
  end

  // State and output registers; start_q resets high so a held key cannot start a game.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      tick_cnt_q   <= '0;
      period_q     <= BASE_P;
      level_q      <= 3'd0;
      score_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      food_tmo_q   <= 1'b0;
      move_tick_q  <= 1'b0;
      game_reset_q <= 1'b1;
      playing_q    <= 1'b0;
      game_won_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start;
      tick_cnt_q   <= tick_cnt_d;
      period_q     <= period_d;
      level_q      <= level_d;
      score_cnt_q  <= score_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      food_tmo_q   <= food_tmo_d;
      move_tick_q  <= move_tick_d;
      game_reset_q <= game_reset_d;
      playing_q    <= playing_d;
      game_won_q   <= game_won_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.move_tick  = move_tick_q;
  assign bus.game_reset = game_reset_q;
  assign bus.playing    = playing_q;
  assign bus.game_won   = game_won_q;
  assign bus.game_over  = game_over_q;
  assign bus.food_tmo   = food_tmo_q;
  assign bus.level      = level_q;

endmodule
